// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared BCD digit type, digit limit and tick/carry helper for
//               the stopwatch_lap block.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Shared by the prescaler tick and the digit-to-digit carry.
    function automatic logic tick_carry(input logic cin, input logic at_max);
        return cin & at_max;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_lap_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One decimal counter digit; advances on cin and carries out
//               when it wraps from 9 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cin,
    output bcd_t q,
    output logic cout
);

    bcd_t r_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (cin) begin
            // >= keeps the digit inside 0..9 even from an unreachable code.
            r_q <= (r_q >= BCD_MAX) ? '0 : r_q + 4'd1;
        end
    end

    assign q    = r_q;
    assign cout = tick_carry(cin, r_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_lap.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_lap
// Description : Prescaled NDIG-digit BCD stopwatch with sticky overflow and a
//               lap-freeze display, built only with STOPWATCH_LAP_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int NDIG     = 3,
    parameter int PRESCALE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic            lap,
    output logic [NDIG*4-1:0] disp,
    output logic [NDIG*4-1:0] live,
    output logic            lap_active,
    output logic            ovf
);

    localparam int             c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0] r_pre;
    logic            w_tick;
    logic [NDIG:0]   w_carry;
    logic            r_ovf;

    assign w_tick = tick_carry(en, r_pre == c_PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
        end
    end

    assign w_carry[0] = w_tick;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        bcd_digit u_digit (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr),
            .cin  (w_carry[i]),
            .q    (live[4*i +: 4]),
            .cout (w_carry[i+1])
        );
    end

    // A carry out of the top digit means the count wrapped from all nines.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_carry[NDIG]) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;

`ifdef STOPWATCH_LAP_EN
    logic [NDIG*4-1:0] r_lap;
    logic              r_lap_active;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lap        <= '0;
            r_lap_active <= 1'b0;
        end else if (clr) begin
            r_lap        <= '0;
            r_lap_active <= 1'b0;
        end else if (lap) begin
            if (!r_lap_active) begin
                r_lap <= live;
            end
            r_lap_active <= ~r_lap_active;
        end
    end

    assign lap_active = r_lap_active;
    assign disp       = r_lap_active ? r_lap : live;
`else
    logic w_unused_lap;

    assign w_unused_lap = lap;
    assign lap_active   = 1'b0;
    assign disp         = live;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_lap
// Description : Scoreboard bench driving PRESCALE=1 and PRESCALE=4 instances
//               of stopwatch_lap from shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_lap;

`ifdef STOPWATCH_LAP_EN
    localparam bit c_LAP = 1'b1;
`else
    localparam bit c_LAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, clr, lap;
    logic [11:0] disp1, live1, disp4, live4;
    logic        la1, ovf1, la4, ovf4;

    stopwatch_lap #(.NDIG(3), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .lap(lap),
        .disp(disp1), .live(live1), .lap_active(la1), .ovf(ovf1)
    );

    stopwatch_lap #(.NDIG(3), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .lap(lap),
        .disp(disp4), .live(live4), .lap_active(la4), .ovf(ovf4)
    );

    typedef struct packed {
        logic [1:0][11:0] live;
        logic [1:0][11:0] disp;
        logic [1:0]       la;
        logic [1:0]       ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int   m_cnt [2];
    int   m_pre [2];
    int   m_lapv[2];
    int   m_ps  [2] = '{1, 4};
    logic m_ovf [2];
    logic m_la  [2];

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model: integer count converted to BCD only for comparison.
    task automatic model_step();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst || clr) begin
                m_cnt[d]  = 0;
                m_pre[d]  = 0;
                m_ovf[d]  = 1'b0;
                m_la[d]   = 1'b0;
                m_lapv[d] = 0;
            end else begin
                if (c_LAP && lap) begin
                    if (!m_la[d]) begin
                        m_lapv[d] = m_cnt[d];
                        m_la[d]   = 1'b1;
                    end else begin
                        m_la[d]   = 1'b0;
                    end
                end
                if (en) begin
                    if (m_pre[d] == m_ps[d] - 1) begin
                        m_pre[d] = 0;
                        if (m_cnt[d] == 999) begin
                            m_cnt[d] = 0;
                            m_ovf[d] = 1'b1;
                        end else begin
                            m_cnt[d]++;
                        end
                    end else begin
                        m_pre[d]++;
                    end
                end
            end
            e.live[d] = to_bcd(m_cnt[d]);
            e.disp[d] = m_la[d] ? to_bcd(m_lapv[d]) : to_bcd(m_cnt[d]);
            e.la[d]   = m_la[d];
            e.ovf[d]  = m_ovf[d];
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic e_in, input logic c, input logic l,
                       input string tag);
        exp_t e;
        rst = r;
        en  = e_in;
        clr = c;
        lap = l;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "/live1"}, live1, e.live[0]);
        check({tag, "/disp1"}, disp1, e.disp[0]);
        check({tag, "/la1"},   {11'b0, la1},  {11'b0, e.la[0]});
        check({tag, "/ovf1"},  {11'b0, ovf1}, {11'b0, e.ovf[0]});
        check({tag, "/live4"}, live4, e.live[1]);
        check({tag, "/disp4"}, disp4, e.disp[1]);
        check({tag, "/la4"},   {11'b0, la4},  {11'b0, e.la[1]});
        check({tag, "/ovf4"},  {11'b0, ovf4}, {11'b0, e.ovf[1]});
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; clr = 1'b0; lap = 1'b0;

        repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, "rst");
        check("rst_live", live1, 12'h000);
        check("rst_disp", disp1, 12'h000);
        check("rst_ovf",  {11'b0, ovf1}, 12'h000);
        check("rst_la",   {11'b0, la1},  12'h000);

        repeat (40) cyc(1'b1, 1'b1, 1'b0, 1'b0, "run");
        check("ps4_40", live4, 12'h010);
        repeat (210) cyc(1'b1, 1'b1, 1'b0, 1'b0, "run");
        check("cnt250", live1, 12'h250);
        check("ps4_250", live4, 12'h062);

        repeat (500) cyc(1'b1, 1'b0, 1'b0, 1'b0, "hold");
        check("hold250", live1, 12'h250);
        check("hold_ps4", live4, 12'h062);

        cyc(1'b1, 1'b1, 1'b0, 1'b0, "resume");
        check("resume1", live4, 12'h062);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "resume");
        check("resume2", live4, 12'h063);
        repeat (8) cyc(1'b1, 1'b1, 1'b0, 1'b0, "resume");
        check("cnt260", live1, 12'h260);
        check("ps4_265", live4, 12'h065);

        while (m_cnt[0] != 999) cyc(1'b1, 1'b1, 1'b0, 1'b0, "to999");
        check("at999", live1, 12'h999);
        check("at999_ovf", {11'b0, ovf1}, 12'h000);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "wrap");
        check("wrap_live", live1, 12'h000);
        check("wrap_ovf", {11'b0, ovf1}, 12'h001);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, "post");
        check("post_live", live1, 12'h005);
        check("post_ovf", {11'b0, ovf1}, 12'h001);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "clr");
        check("clr_live", live1, 12'h000);
        check("clr_ovf", {11'b0, ovf1}, 12'h000);

        repeat (123) cyc(1'b1, 1'b1, 1'b0, 1'b0, "to123");
        check("at123", live1, 12'h123);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "lap1");
        repeat (9) cyc(1'b1, 1'b1, 1'b0, 1'b0, "lapfrz");
        check("lap_live", live1, 12'h133);
        check("lap_disp", disp1, c_LAP ? 12'h123 : 12'h133);
        check("lap_act",  {11'b0, la1}, {11'b0, c_LAP});
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "lap2");
        check("lap2_disp", disp1, 12'h133);
        check("lap2_act", {11'b0, la1}, 12'h000);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, "clr2");
        repeat (70) cyc(1'b1, 1'b1, 1'b0, 1'b0, "to70");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "lap3");
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0, "to77");
        check("at077", live1, 12'h077);
        check("at077_disp", disp1, c_LAP ? 12'h070 : 12'h077);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, "clrlap");
        check("clrlap_live", live1, 12'h000);
        check("clrlap_disp", disp1, 12'h000);
        check("clrlap_act", {11'b0, la1}, 12'h000);

        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1, "laphold");
        check("hold3_live", live1, 12'h003);
        check("hold3_disp", disp1, c_LAP ? 12'h002 : 12'h003);
        check("hold3_act", {11'b0, la1}, {11'b0, c_LAP});

        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, "prerst");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, "rstprio");
        check("rstp_live1", live1, 12'h000);
        check("rstp_disp1", disp1, 12'h000);
        check("rstp_act", {11'b0, la1}, 12'h000);
        check("rstp_live4", live4, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter NDIG, default 3, number of BCD digits (1..8).
REQ-002 SHALL have parameter PRESCALE, default 1, enabled clock cycles per count tick (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  run enable; 0 = hold count and prescaler.
REQ-006 SHALL have port clr  input  1  synchronous clear of count, prescaler, ovf and lap state.
REQ-007 SHALL have port lap  input  1  single-cycle lap toggle pulse.
REQ-008 SHALL have port disp  output  NDIG x 4 (packed, digit 0 = LSD)  displayed BCD value.
REQ-009 SHALL have port live  output  NDIG x 4  running BCD count, never frozen.
REQ-010 SHALL have port lap_active  output  1  display frozen on a lap value.
REQ-011 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-012 SHALL hold a prescaler counter pre in 0..PRESCALE-1, advanced only when en=1; tick = en & (pre==PRESCALE-1), then pre wraps to 0.
REQ-013 SHALL increment live by one decimal unit on the clock edge at which tick=1 (one-cycle latency: live visible the following cycle).
REQ-014 SHALL propagate carry: digit at 9 with carry-in goes to 0 and carries out; digits above receive carry only when all lower digits are 9.
REQ-015 SHALL never produce non-BCD digit values (A..F).
REQ-016 SHALL wrap all-9s plus tick to all-0s and set ovf=1 on that edge; ovf stays 1 until clr or reset.
REQ-017 SHALL, with en=0, hold live and pre unchanged; re-asserting en resumes with the retained pre value.
REQ-018 SHALL, on lap=1 with lap_active=0, capture live's pre-edge value into a lap register and set lap_active=1.
REQ-019 SHALL, on lap=1 with lap_active=1, clear lap_active; lap register content is then don't-care.
REQ-020 SHALL drive disp = lap register when lap_active=1, else disp = live (combinational mux of registered values).
REQ-021 SHALL keep counting live while lap_active=1 and while lap is asserted.
REQ-022 SHALL give clr priority over tick and lap on the same edge: live=0, pre=0, ovf=0, lap_active=0.
REQ-023 SHALL treat lap held high for k cycles as k toggles (no edge detection inside block).

Reset
REQ-024 SHALL, on rising clk with rst=0, set live=0, pre=0, lap register=0, lap_active=0, ovf=0; disp reads 0 the next cycle.
REQ-025 SHALL give rst priority over clr, en, and lap; reset mid-count discards all state.

Configuration
REQ-026 SHALL compile the lap feature only when macro STOPWATCH_LAP_EN is defined.
REQ-027 SHALL, without STOPWATCH_LAP_EN, omit the lap register, ignore lap, tie lap_active=0, and drive disp=live; ports are unchanged.

Structure
REQ-028 SHALL place typedef bcd_t (4-bit digit), constant BCD_MAX=4'd9 and the tick/carry helper in package stopwatch_pkg.
REQ-029 SHALL implement each digit as sub-module bcd_digit (inputs clk, rst, clr, cin; outputs q, cout), instantiated NDIG times in a generate loop.

Verification
REQ-030 SHALL cover reset: NDIG=3, PRESCALE=1, rst=0 two cycles with en=1 -> live=disp=000, ovf=0, lap_active=0.
REQ-031 SHALL cover counting and hold: en=1 250 cycles -> live=250; en=0 500 cycles -> live stays 250; en=1 10 cycles -> 260.
REQ-032 SHALL cover overflow: run to 999, one more tick -> live=000, ovf=1; 5 more ticks -> 005, ovf still 1; clr -> 000, ovf=0.
REQ-033 SHALL cover lap: lap pulse at live=123, 10 ticks -> disp=123, live=133; second lap -> disp=133, lap_active=0.
REQ-034 SHALL cover prescale: PRESCALE=4, en=1 40 cycles from reset -> live=010; en dropped at pre=2 then resumed -> next tick after 1 enabled cycle.
REQ-035 SHALL cover priority: clr and lap together at live=077 -> live=000, lap_active=0; build without STOPWATCH_LAP_EN -> lap ignored, disp=live throughout.
